// File: rtl/im_fetch_ctrl_pkg.sv
// Shared constants and state type for the instruction-fetch sequencer.
package im_fetch_ctrl_pkg;

   localparam int WORD_SIZE  = 19;
   localparam int IM_ADDR_W  = 10;
   localparam int OPCODE_MSB = 18;
   localparam int OPCODE_LSB = 14;

   localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE_DEF = 5'b11111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RESP = 3'd2,
      HOLD = 3'd3,
      HALT = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register: load (start/redirect) beats increment; increment wraps at 2**ADDR_W.
module fetch_pc_reg
   import im_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = IM_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_seq
);

   assign pc_seq = pc + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         pc <= pc_seq;
      end
   end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: drives instruction-memory reads and hands instructions to decode.
// Optional performance counters are built only when IM_FETCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start after reset
// REQ   | read issued at pc
// RESP  | read data arriving, captured into instr
// HOLD  | instr_valid high, waiting for decode to accept
// HALT  | HALT opcode consumed, waiting for start
module im_fetch_ctrl
   import im_fetch_ctrl_pkg::*;
#(
   parameter int                                ADDR_W      = IM_ADDR_W,
   parameter int                                WORD_W      = WORD_SIZE,
   parameter logic [ADDR_W-1:0]                 RESET_PC    = '0,
   parameter logic [OPCODE_MSB-OPCODE_LSB:0]    HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   output logic              im_rd_en,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [WORD_W-1:0] im_rdata,
   output logic [WORD_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              dec_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              halted,
   output logic [15:0]       fetch_count,
   output logic [15:0]       stall_count
);

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_seq, pc_load_addr;
   logic              pc_load, pc_inc;
   logic              capture, clr_valid, set_halt, clr_halt;
   logic              accept, stall, perf_clr;

   fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
      .clk       (CLK),
      .reset     (RESET),
      .load      (pc_load),
      .load_addr (pc_load_addr),
      .inc       (pc_inc),
      .pc        (pc),
      .pc_seq    (pc_seq)
   );

   always_comb begin
      state_nxt    = state;
      im_rd_en     = 1'b0;
      im_addr      = '0;
      pc_load      = 1'b0;
      pc_load_addr = RESET_PC;
      pc_inc       = 1'b0;
      capture      = 1'b0;
      clr_valid    = 1'b0;
      set_halt     = 1'b0;
      clr_halt     = 1'b0;
      accept       = 1'b0;
      stall        = 1'b0;
      perf_clr     = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               pc_load   = 1'b1;
               clr_halt  = 1'b1;
               perf_clr  = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               pc_load      = 1'b1;
               pc_load_addr = redirect_addr;
               state_nxt    = REQ;
            end else begin
               im_rd_en  = 1'b1;
               im_addr   = pc;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (redirect_valid) begin
               pc_load      = 1'b1;
               pc_load_addr = redirect_addr;
               state_nxt    = REQ;
            end else begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            accept = dec_ready;
            stall  = ~dec_ready;
            // A same-cycle accept still consumes the instruction, but the redirect wins the fetch.
            if (redirect_valid) begin
               pc_load      = 1'b1;
               pc_load_addr = redirect_addr;
               clr_valid    = 1'b1;
               state_nxt    = REQ;
            end else if (dec_ready) begin
               clr_valid = 1'b1;
               if (instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                  set_halt  = 1'b1;
                  state_nxt = HALT;
               end else begin
                  im_rd_en  = 1'b1;
                  im_addr   = pc_seq;
                  pc_inc    = 1'b1;
                  state_nxt = RESP;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            instr    <= im_rdata;
            instr_pc <= pc;
         end
         if (capture) begin
            instr_valid <= 1'b1;
         end else if (clr_valid) begin
            instr_valid <= 1'b0;
         end
         if (set_halt) begin
            halted <= 1'b1;
         end else if (clr_halt) begin
            halted <= 1'b0;
         end
      end
   end

`ifdef IM_FETCH_PERF_EN
   always_ff @(posedge CLK) begin
      if (RESET || perf_clr) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (accept && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
         end
         if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end
`else
   logic unused_perf;
   assign unused_perf = accept ^ stall ^ perf_clr;
   assign fetch_count = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: per-cycle vector table plus redirect, wrap and reset sequences.
module tb_im_fetch_ctrl;

`ifdef IM_FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        RESET;
   logic        start, dec_ready, redirect_valid;
   logic [9:0]  redirect_addr;
   logic        im_rd_en;
   logic [9:0]  im_addr;
   logic [18:0] im_rdata;
   logic [18:0] instr;
   logic [9:0]  instr_pc;
   logic        instr_valid, halted;
   logic [15:0] fetch_count, stall_count;

   logic [18:0] mem [1024];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (im_rd_en) im_rdata <= mem[im_addr];
   end

   im_fetch_ctrl dut (
      .CLK            (clk),
      .RESET          (RESET),
      .start          (start),
      .im_rd_en       (im_rd_en),
      .im_addr        (im_addr),
      .im_rdata       (im_rdata),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .dec_ready      (dec_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted),
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
   );

   typedef struct {
      logic        start;
      logic        rdy;
      logic        rv;
      logic [9:0]  ra;
      logic        e_rd;
      logic [9:0]  e_addr;
      logic        e_valid;
      logic [18:0] e_instr;
      logic [9:0]  e_ipc;
      logic        e_halted;
      logic [15:0] e_fc;
      logic [15:0] e_sc;
   } vec_t;

   vec_t v [18];

   function automatic vec_t mk(input logic s, input logic r, input logic rv, input logic [9:0] ra,
                               input logic rd, input logic [9:0] ad, input logic vl,
                               input logic [18:0] ins, input logic [9:0] ipc, input logic hl,
                               input logic [15:0] fc, input logic [15:0] sc);
      vec_t t;
      t.start = s;  t.rdy = r;  t.rv = rv;  t.ra = ra;
      t.e_rd = rd;  t.e_addr = ad;  t.e_valid = vl;  t.e_instr = ins;
      t.e_ipc = ipc;  t.e_halted = hl;  t.e_fc = fc;  t.e_sc = sc;
      return t;
   endfunction

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h, expected %h", name, tag, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic r, input logic rv, input logic [9:0] ra);
      @(negedge clk);
      start          = s;
      dec_ready      = r;
      redirect_valid = rv;
      redirect_addr  = ra;
      #1;
   endtask

   task automatic chk_out(input int tag, input logic rd, input logic [9:0] ad, input logic vl,
                          input logic [18:0] ins, input logic [9:0] ipc);
      chk("im_rd_en", tag, 32'(im_rd_en), 32'(rd));
      if (rd) chk("im_addr", tag, 32'(im_addr), 32'(ad));
      chk("instr_valid", tag, 32'(instr_valid), 32'(vl));
      chk("instr", tag, 32'(instr), 32'(ins));
      chk("instr_pc", tag, 32'(instr_pc), 32'(ipc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 19'h0;
      mem[0]      = 19'h00001;
      mem[1]      = 19'h00002;
      mem[2]      = 19'h7C000;
      mem[5]      = 19'h05555;
      mem[10'h200] = 19'h12345;
      mem[10'h3FF] = 19'h00777;

      //       start rdy   rv    ra      rd    addr    vld   instr       ipc     halt  fc     sc
      v[0]  = mk(1'b1,1'b1,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h00000,10'h000,1'b0,16'd0,16'd0);
      v[1]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b1,10'h000,1'b0,19'h00000,10'h000,1'b0,16'd0,16'd0);
      v[2]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h00000,10'h000,1'b0,16'd0,16'd0);
      v[3]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b1,10'h001,1'b1,19'h00001,10'h000,1'b0,16'd0,16'd0);
      v[4]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h00001,10'h000,1'b0,16'd1,16'd0);
      v[5]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b1,10'h002,1'b1,19'h00002,10'h001,1'b0,16'd1,16'd0);
      v[6]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h00002,10'h001,1'b0,16'd2,16'd0);
      v[7]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b0,10'h000,1'b1,19'h7C000,10'h002,1'b0,16'd2,16'd0);
      v[8]  = mk(1'b0,1'b1,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h7C000,10'h002,1'b1,16'd3,16'd0);
      v[9]  = mk(1'b0,1'b1,1'b1,10'h155, 1'b0,10'h000,1'b0,19'h7C000,10'h002,1'b1,16'd3,16'd0);
      v[10] = mk(1'b1,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h7C000,10'h002,1'b1,16'd3,16'd0);
      v[11] = mk(1'b0,1'b0,1'b0,10'h000, 1'b1,10'h000,1'b0,19'h7C000,10'h002,1'b0,16'd0,16'd0);
      v[12] = mk(1'b0,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b0,19'h7C000,10'h002,1'b0,16'd0,16'd0);
      v[13] = mk(1'b0,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b1,19'h00001,10'h000,1'b0,16'd0,16'd0);
      v[14] = mk(1'b1,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b1,19'h00001,10'h000,1'b0,16'd0,16'd1);
      v[15] = mk(1'b0,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b1,19'h00001,10'h000,1'b0,16'd0,16'd2);
      v[16] = mk(1'b0,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b1,19'h00001,10'h000,1'b0,16'd0,16'd3);
      v[17] = mk(1'b0,1'b0,1'b0,10'h000, 1'b0,10'h000,1'b1,19'h00001,10'h000,1'b0,16'd0,16'd4);

      RESET = 1'b1;
      start = 1'b0;  dec_ready = 1'b0;  redirect_valid = 1'b0;  redirect_addr = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_out(-1, 1'b0, 10'h000, 1'b0, 19'h00000, 10'h000);
      chk("halted", -1, 32'(halted), 32'd0);
      chk("fetch_count", -1, 32'(fetch_count), 32'd0);
      chk("stall_count", -1, 32'(stall_count), 32'd0);
      chk("im_addr_reset", -1, 32'(im_addr), 32'd0);
      RESET = 1'b0;

      // Program run to HALT, restart from HALT, then a five-cycle decode stall.
      for (int i = 0; i < 18; i++) begin
         step(v[i].start, v[i].rdy, v[i].rv, v[i].ra);
         chk_out(i, v[i].e_rd, v[i].e_addr, v[i].e_valid, v[i].e_instr, v[i].e_ipc);
         chk("halted", i, 32'(halted), 32'(v[i].e_halted));
         chk("fetch_count", i, 32'(fetch_count), 32'(PERF ? v[i].e_fc : 16'd0));
         chk("stall_count", i, 32'(stall_count), 32'(PERF ? v[i].e_sc : 16'd0));
      end

      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk("stall_count_5", 18, 32'(stall_count), 32'(PERF ? 16'd5 : 16'd0));
      chk_out(18, 1'b0, 10'h000, 1'b1, 19'h00001, 10'h000);

      // Redirect to 0x005, then redirect to 0x200 while pc 0x005 is in RESP.
      step(1'b0, 1'b0, 1'b1, 10'h005);
      chk("rd_en_redir_hold", 20, 32'(im_rd_en), 32'd0);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk_out(21, 1'b1, 10'h005, 1'b0, 19'h00001, 10'h000);
      step(1'b0, 1'b0, 1'b1, 10'h200);
      chk_out(22, 1'b0, 10'h000, 1'b0, 19'h00001, 10'h000);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk_out(23, 1'b1, 10'h200, 1'b0, 19'h00001, 10'h000);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk_out(24, 1'b0, 10'h000, 1'b0, 19'h00001, 10'h000);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk_out(25, 1'b0, 10'h000, 1'b1, 19'h12345, 10'h200);

      // Sequential fetch across the top of the address space.
      step(1'b0, 1'b0, 1'b1, 10'h3FF);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk_out(31, 1'b1, 10'h3FF, 1'b0, 19'h12345, 10'h200);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      step(1'b0, 1'b1, 1'b0, 10'h000);
      chk_out(33, 1'b1, 10'h000, 1'b1, 19'h00777, 10'h3FF);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      step(1'b0, 1'b1, 1'b0, 10'h000);
      chk_out(35, 1'b1, 10'h001, 1'b1, 19'h00001, 10'h000);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      step(1'b0, 1'b0, 1'b0, 10'h000);
      chk_out(37, 1'b0, 10'h000, 1'b1, 19'h00002, 10'h001);

      // Reset while HOLD presents a valid instruction.
      @(negedge clk);
      RESET = 1'b1;
      @(negedge clk);
      RESET = 1'b0;
      #1;
      chk_out(40, 1'b0, 10'h000, 1'b0, 19'h00000, 10'h000);
      chk("halted", 40, 32'(halted), 32'd0);
      chk("fetch_count", 40, 32'(fetch_count), 32'd0);
      chk("stall_count", 40, 32'(stall_count), 32'd0);
      step(1'b0, 1'b1, 1'b0, 10'h000);
      chk("rd_en_idle", 41, 32'(im_rd_en), 32'd0);
      step(1'b1, 1'b1, 1'b0, 10'h000);
      chk("rd_en_start", 42, 32'(im_rd_en), 32'd0);
      step(1'b0, 1'b1, 1'b0, 10'h000);
      chk_out(43, 1'b1, 10'h000, 1'b0, 19'h00000, 10'h000);
      step(1'b0, 1'b1, 1'b0, 10'h000);
      step(1'b0, 1'b1, 1'b0, 10'h000);
      chk_out(45, 1'b1, 10'h001, 1'b1, 19'h00001, 10'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
